// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (RV32M DIV/DIVU/REM/REMU), one quotient bit per clock.
// Optional SEQ_DIVIDER_EARLY_OUT_EN: divide-by-zero and signed overflow bypass RUN.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             signed_reg;
  logic [WIDTH-1:0] q_reg, d_reg, rem_reg;
  logic [CW-1:0]    cnt_reg;
  logic             sign_q_reg, sign_r_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             dz_reg;

  logic             accept;
  logic             b_zero, overflow;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   partial, diff;
  logic             ge;
  logic [WIDTH-1:0] q_fix, rem_fix;

  assign accept   = start && (state_reg == IDLE || state_reg == DONE);
  assign b_zero   = (b_reg == '0);
  assign overflow = signed_reg && (a_reg == MIN_NEG) && (b_reg == '1);
  assign a_abs    = (signed_reg && a_reg[WIDTH-1]) ? -a_reg : a_reg;
  assign b_abs    = (signed_reg && b_reg[WIDTH-1]) ? -b_reg : b_reg;

  // Sign bit of the (WIDTH+1)-bit difference is the trial-subtract borrow.
  assign partial  = {rem_reg, q_reg[WIDTH-1]};
  assign diff     = partial - {1'b0, d_reg};
  assign ge       = ~diff[WIDTH];

  always_comb begin
    q_fix   = sign_q_reg ? -q_reg : q_reg;
    rem_fix = sign_r_reg ? -rem_reg : rem_reg;
    if (b_zero) begin
      q_fix   = '1;
      rem_fix = a_reg;
    end else if (overflow) begin
      q_fix   = a_reg;
      rem_fix = '0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = PREP;
      PREP: begin
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
        state_next = (b_zero || overflow) ? FIX : RUN;
`else
        state_next = RUN;
`endif
      end
      RUN:  if (cnt_reg == CW'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = accept ? PREP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_reg == PREP) || (state_reg == RUN) || (state_reg == FIX);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg         <= '0;
      b_reg         <= '0;
      signed_reg    <= 1'b0;
      q_reg         <= '0;
      d_reg         <= '0;
      rem_reg       <= '0;
      cnt_reg       <= '0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dz_reg        <= 1'b0;
    end else begin
      if (accept) begin
        a_reg         <= dividend;
        b_reg         <= divisor;
        signed_reg    <= op_signed;
        quotient_reg  <= '0;
        remainder_reg <= '0;
        dz_reg        <= 1'b0;
      end
      case (state_reg)
        PREP: begin
          sign_q_reg <= signed_reg && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
          sign_r_reg <= signed_reg && a_reg[WIDTH-1];
          q_reg      <= a_abs;
          d_reg      <= b_abs;
          rem_reg    <= '0;
          cnt_reg    <= CW'(WIDTH);
          dz_reg     <= b_zero;
        end
        RUN: begin
          q_reg   <= {q_reg[WIDTH-2:0], ge};
          rem_reg <= ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
          cnt_reg <= cnt_reg - 1'b1;
        end
        FIX: begin
          quotient_reg  <= q_fix;
          remainder_reg <= rem_fix;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32), incl. handshake and reset abort.
// Latency of the special cases follows SEQ_DIVIDER_EARLY_OUT_EN when it is defined.
module tb_seq_divider;

  localparam int W = 32;
  localparam int FULL_LAT = W + 2;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 2;
`else
  localparam int SPECIAL_LAT = W + 2;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int pass_cnt = 0;
  int total_cnt = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_signed(op_signed),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Issues one operation from the current cycle and waits (bounded) for done.
  // inject_edge>0 raises a competing start sampled at that edge after acceptance.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input int inject_edge, output int lat,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    lat = -1; q = '0; r = '0; dz = 1'b0;
    dividend = a; divisor = b; op_signed = sgn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; op_signed = 1'($urandom_range(0, 1));
    for (int n = 1; n <= 60; n++) begin
      if (n == inject_edge) begin
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3; op_signed = 1'b0;
      end
      @(posedge clk); #1;
      if (n == inject_edge) start = 1'b0;
      if (done) begin
        lat = n; q = quotient; r = remainder; dz = div_by_zero;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0)
      $display("FAIL reset_outputs got busy=%b done=%b dz=%b q=%h r=%h want all zero",
               busy, done, div_by_zero, quotient, remainder);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    logic [W-1:0] va[4] = '{32'd100, 32'hFFFFFFF9, 32'd5, 32'h80000000};
    logic [W-1:0] vb[4] = '{32'd7, 32'd7, 32'd9, 32'hFFFFFFFF};
    logic [W-1:0] eq[4] = '{32'd14, 32'h24924923, 32'd0, 32'd0};
    logic [W-1:0] er[4] = '{32'd2, 32'd4, 32'd5, 32'h80000000};
    int lat;
    logic [W-1:0] q, r;
    logic dz;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], 1'b0, 0, lat, q, r, dz);
      total_cnt++;
      if (lat !== FULL_LAT || q !== eq[i] || r !== er[i] || dz !== 1'b0)
        $display("FAIL unsigned_%0d got lat=%0d q=%h r=%h dz=%b want lat=%0d q=%h r=%h dz=0",
                 i, lat, q, r, dz, FULL_LAT, eq[i], er[i]);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (done !== 1'b0 || busy !== 1'b0 || quotient !== eq[i] || remainder !== er[i])
        $display("FAIL unsigned_hold_%0d got done=%b busy=%b q=%h r=%h want done=0 busy=0 q=%h r=%h",
                 i, done, busy, quotient, remainder, eq[i], er[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_signed();
    logic [W-1:0] va[3] = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C};
    logic [W-1:0] vb[3] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [W-1:0] eq[3] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14};
    logic [W-1:0] er[3] = '{32'hFFFFFFFE, 32'd2, 32'hFFFFFFFE};
    int lat;
    logic [W-1:0] q, r;
    logic dz;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 1'b1, 0, lat, q, r, dz);
      total_cnt++;
      if (lat !== FULL_LAT || q !== eq[i] || r !== er[i] || dz !== 1'b0)
        $display("FAIL signed_%0d got lat=%0d q=%h r=%h dz=%b want lat=%0d q=%h r=%h dz=0",
                 i, lat, q, r, dz, FULL_LAT, eq[i], er[i]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    logic [W-1:0] q, r;
    logic dz;
    run_op(32'h12345678, 32'd0, 1'b0, 0, lat, q, r, dz);
    total_cnt++;
    if (lat !== SPECIAL_LAT || q !== 32'hFFFFFFFF || r !== 32'h12345678 || dz !== 1'b1)
      $display("FAIL div0_unsigned got lat=%0d q=%h r=%h dz=%b want lat=%0d q=ffffffff r=12345678 dz=1",
               lat, q, r, dz, SPECIAL_LAT);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (div_by_zero !== 1'b1 || done !== 1'b0)
      $display("FAIL div0_hold got dz=%b done=%b want dz=1 done=0", div_by_zero, done);
    else pass_cnt++;
    run_op(32'hFFFFFF9C, 32'd0, 1'b1, 0, lat, q, r, dz);
    total_cnt++;
    if (lat !== SPECIAL_LAT || q !== 32'hFFFFFFFF || r !== 32'hFFFFFF9C || dz !== 1'b1)
      $display("FAIL div0_signed got lat=%0d q=%h r=%h dz=%b want lat=%0d q=ffffffff r=ffffff9c dz=1",
               lat, q, r, dz, SPECIAL_LAT);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int lat;
    logic [W-1:0] q, r;
    logic dz;
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, lat, q, r, dz);
    total_cnt++;
    if (lat !== SPECIAL_LAT || q !== 32'h80000000 || r !== 32'd0 || dz !== 1'b0)
      $display("FAIL overflow got lat=%0d q=%h r=%h dz=%b want lat=%0d q=80000000 r=0 dz=0",
               lat, q, r, dz, SPECIAL_LAT);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int lat;
    logic [W-1:0] q, r;
    logic dz;
    run_op(32'd100, 32'd7, 1'b0, 10, lat, q, r, dz);
    total_cnt++;
    if (lat !== FULL_LAT || q !== 32'd14 || r !== 32'd2)
      $display("FAIL ignore_start got lat=%0d q=%h r=%h want lat=%0d q=e r=2", lat, q, r, FULL_LAT);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL ignore_start_no_queue got busy=%b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [W-1:0] q1, r1, q2, r2;
    logic dz1, dz2;
    run_op(32'd100, 32'd7, 1'b0, 0, lat1, q1, r1, dz1);
    run_op(32'd1000, 32'd3, 1'b0, 0, lat2, q2, r2, dz2);
    total_cnt++;
    if (lat1 !== FULL_LAT || q1 !== 32'd14 || r1 !== 32'd2)
      $display("FAIL b2b_first got lat=%0d q=%h r=%h want lat=%0d q=e r=2", lat1, q1, r1, FULL_LAT);
    else pass_cnt++;
    total_cnt++;
    if (lat2 !== FULL_LAT || q2 !== 32'd333 || r2 !== 32'd1 || dz2 !== 1'b0)
      $display("FAIL b2b_second got lat=%0d q=%h r=%h dz=%b want lat=%0d q=14d r=1 dz=0",
               lat2, q2, r2, dz2, FULL_LAT);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int seen_done;
    dividend = 32'd100; divisor = 32'd7; op_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b1)
      $display("FAIL reset_mid_busy_before got busy=%b want 1", busy);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0)
      $display("FAIL reset_mid_outputs got busy=%b done=%b dz=%b q=%h r=%h want all zero",
               busy, done, div_by_zero, quotient, remainder);
    else pass_cnt++;
    seen_done = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    total_cnt++;
    if (seen_done !== 0)
      $display("FAIL reset_mid_no_done got %0d done cycles want 0", seen_done);
    else pass_cnt++;
  endtask

  initial begin
    #1;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider. It computes quotient and remainder by repeated trial subtraction, one bit per clock.
- It is the subtract-side counterpart to the ripple-carry adder datapath.
- It serves the RV32M DIV/DIVU/REM/REMU path in the execute stage and is driven by a start/done handshake from the ALU control.

Parameters:
- WIDTH, 32, operand and result width in bits; must be at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request pulse; accepted only when busy=0.
- op_signed  input  1  1 selects signed (DIV/REM), 0 selects unsigned (DIVU/REMU); sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  WIDTH  result quotient; held until the next accepted start.
- remainder  output  WIDTH  result remainder; held until the next accepted start.
- div_by_zero  output  1  flag for the last operation; valid with done and held with the results.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; state=IDLE; iteration counter=0.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE/DONE -> PREP on start=1:
  - Latch the operands and op_signed.
  - Clear quotient, remainder and div_by_zero.
  - Set busy=1.
  - start is also accepted in the DONE cycle, enabling back-to-back operation.
- PREP (1 cycle):
  - Record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend), both only when op_signed=1.
  - Replace each operand by its absolute value (two's complement negate when negative and op_signed=1).
  - Load counter = WIDTH.
  - Set div_by_zero = (divisor==0).
- RUN (exactly WIDTH cycles), per cycle:
  - partial = {rem[WIDTH-1:0], q[WIDTH-1]}; q shifts left by 1.
  - If partial >= abs_divisor: rem = partial - abs_divisor and q[0]=1. Otherwise rem = partial and q[0]=0.
  - Use a WIDTH+1-bit compare/subtract so there is no overflow.
  - Decrement counter; go to FIX when counter reaches 1 -> 0.
- FIX (1 cycle):
  - Negate q if sign_q=1; negate rem if sign_r=1.
  - Apply special cases:
    - divisor==0: quotient = all ones, remainder = original dividend.
    - Signed overflow (op_signed, dividend = 100..0, divisor = all ones): quotient = dividend, remainder = 0.
- DONE (1 cycle):
  - done=1, busy=0; results are visible on the outputs.
  - Next state is IDLE, or PREP if start=1.
- Latency: done is high in the cycle following the (WIDTH+2)th rising edge after the edge that sampled start. For WIDTH=32 that is 34 edges.
- start while busy=1 is ignored: no effect on the operation in progress, no queueing.
- Operand inputs may change after acceptance without effect.
- rst mid-operation aborts the operation: next cycle is IDLE with all outputs at reset values, and no done pulse is produced.
- Sign rule: the remainder takes the sign of the dividend; the quotient truncates toward zero (RISC-V semantics).

Optional Feature:
- Macro: SEQ_DIVIDER_EARLY_OUT_EN
- Defined: in PREP, divide-by-zero and signed overflow skip RUN and go directly to FIX. done then rises 2 edges after the accepting edge, with the same special-case result values.
- Undefined: every operation, including the special cases, takes the full WIDTH+2 latency. Special-case values are still applied in FIX.

Test Plan:
- Unsigned: start, op_signed=0, dividend=100, divisor=7 -> after 34 edges done=1 for exactly one cycle, quotient=14, remainder=2, div_by_zero=0.
- Signed: dividend=-100 (0xFFFFFF9C), divisor=7, op_signed=1 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE).
- Divide by zero: dividend=0x12345678, divisor=0 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1. Latency is 34 edges without the macro, 2 with SEQ_DIVIDER_EARLY_OUT_EN.
- Signed overflow: dividend=0x80000000, divisor=0xFFFFFFFF, op_signed=1 -> quotient=0x80000000, remainder=0.
- Handshake:
  - Assert start again at edge 10 of an operation with different operands -> ignored; the first result is unchanged.
  - Assert start in the DONE cycle -> second operation accepted, its done arrives 34 edges later.
- Reset mid-operation: assert rst at edge 15 for one cycle -> next cycle busy=0, outputs=0, and no done pulse within the following 40 cycles.
